// File: rtl/uart_rx16.sv
// 8-bit UART receiver (8N1, LSB first) sampling on a 16x baud strobe, feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx16 #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_16_x_baud,
    input  logic       serial_in,
    input  logic       read_buffer,
    output logic [7:0] data_out,
    output logic       data_present,
    output logic       buffer_half_full,
    output logic       buffer_full,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
`endif

    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] HALF_CNT = (FIFO_AW+1)'(FIFO_DEPTH / 2);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    logic [1:0]         sync_r;
    logic               rx_s;
    logic [2:0]         state_r, state_s;
    logic [3:0]         tick_cnt_r, tick_s;
    logic [2:0]         bit_cnt_r, bit_s;
    logic [7:0]         shift_r, shift_s;
    logic               par_bad_r, par_bad_s;
    logic               wr_req_s;
    logic               frame_err_s;
`ifdef UART_RX_PARITY_EN
    logic               par_err_s;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               rd_valid_s;
    logic               wr_ok_s;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous RX line, idling high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], serial_in};
        end
    end

    // Receive FSM next-state logic; everything holds between baud ticks.
    always_comb begin
        state_s     = state_r;
        tick_s      = tick_cnt_r;
        bit_s       = bit_cnt_r;
        shift_s     = shift_r;
        par_bad_s   = par_bad_r;
        wr_req_s    = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_s   = 1'b0;
`endif
        if (en_16_x_baud) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_s = START;
                        tick_s  = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == 4'd7) begin
                        tick_s = 4'd0;
                        if (!rx_s) begin
                            state_s   = DATA;
                            bit_s     = 3'd0;
                            par_bad_s = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        tick_s = tick_cnt_r + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == 4'd15) begin
                        tick_s  = 4'd0;
                        shift_s = {rx_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_s = PARITY;
`else
                            state_s = STOP;
`endif
                        end else begin
                            bit_s = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tick_s = tick_cnt_r + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_r == 4'd15) begin
                        tick_s  = 4'd0;
                        state_s = STOP;
                        if (parity_bad(shift_r, rx_s)) begin
                            par_err_s = 1'b1;
                            par_bad_s = 1'b1;
                        end else begin
                            par_bad_s = 1'b0;
                        end
                    end else begin
                        tick_s = tick_cnt_r + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt_r == 4'd15) begin
                        tick_s = 4'd0;
                        if (rx_s) begin
                            state_s = IDLE;
                            if (!par_bad_r) begin
                                wr_req_s = 1'b1;
                            end else begin
                                wr_req_s = 1'b0;
                            end
                        end else begin
                            frame_err_s = 1'b1;
                            state_s     = WAIT_HIGH;
                        end
                    end else begin
                        tick_s = tick_cnt_r + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_HIGH;
                    end
                end
                default: begin
                    state_s = IDLE;
                    tick_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Receive FSM state and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tick_cnt_r  <= 4'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_bad_r   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_r     <= state_s;
            tick_cnt_r  <= tick_s;
            bit_cnt_r   <= bit_s;
            shift_r     <= shift_s;
            par_bad_r   <= par_bad_s;
            frame_error <= frame_err_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= par_err_s;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    // A full FIFO still accepts a byte when the head is popped on the same clock.
    assign data_present     = (count_r != {(FIFO_AW+1){1'b0}});
    assign buffer_half_full = (count_r >= HALF_CNT);
    assign buffer_full      = (count_r == FULL_CNT);
    assign rd_valid_s       = read_buffer && data_present;
    assign wr_ok_s          = wr_req_s && ((count_r != FULL_CNT) || rd_valid_s);
    assign data_out         = data_present ? mem[rd_ptr_r] : 8'h00;

    // FIFO storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
            overrun  <= 1'b0;
        end else begin
            overrun <= wr_req_s && !wr_ok_s;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (rd_valid_s) begin
                rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            case ({wr_ok_s, rd_valid_s})
                2'b10:   count_r <= count_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: doc/uart_rx16.md
Name: uart_rx16

Overview:
- 8-bit UART receiver that consumes the single-cycle en_16_x_baud strobe from the baud generator; default framing is 8N1, LSB first.
- Samples each bit at its 16x-oversampled midpoint, checks the stop bit, and pushes good bytes into a first-word-fall-through receive FIFO.
- Sits between the RS232 pin and the host-side controller that reads bytes with read_buffer.

Parameters:
FIFO_DEPTH, 16, receive FIFO depth; power of two, 2..64.
FIFO_AW, 4, log2(FIFO_DEPTH); the instantiator must keep it consistent with FIFO_DEPTH.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
en_16_x_baud  input  1  one-clk strobe at 16x the baud rate.
serial_in  input  1  asynchronous RX line; idle high.
read_buffer  input  1  pops the FIFO head on this clk if data_present=1; ignored when empty.
data_out  output  8  FIFO head byte; 8'h00 when data_present=0.
data_present  output  1  FIFO count != 0.
buffer_half_full  output  1  count >= FIFO_DEPTH/2.
buffer_full  output  1  count == FIFO_DEPTH.
frame_error  output  1  one-clk pulse when the stop bit is sampled as 0.
overrun  output  1  one-clk pulse when a good byte is dropped because the FIFO is full.
parity_error  output  1  one-clk pulse on parity mismatch (see Optional Feature).

Behaviour:
- Synchronizer: serial_in passes through 2 flops (reset to 1) to give rx_s. All decisions use rx_s and advance only on clks where en_16_x_baud=1; between ticks all state holds.
- Counters: tick_cnt is 4 bits and wraps 15->0. bit_cnt is 3 bits. shift_reg is 8 bits and shifts right, inserting rx_s at bit 7.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: on a tick with rx_s=0 -> START, tick_cnt=0.
- START: on each tick tick_cnt++. At the tick where tick_cnt==7 (mid start bit):
  - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1 -> IDLE (glitch rejected, no error).
- DATA: on the tick where tick_cnt==15, sample rx_s into shift_reg and set tick_cnt=0. After the 8th sample (bit_cnt==7) -> STOP (or PARITY); otherwise bit_cnt++.
- STOP: on the tick where tick_cnt==15:
  - rx_s=1 and no pending parity error -> write shift_reg to the FIFO, go to IDLE.
  - rx_s=1 with a pending parity error -> byte discarded, go to IDLE.
  - rx_s=0 -> frame_error pulse, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH: on a tick with rx_s=1 -> IDLE. A line held low (break) yields exactly one frame_error.
- Latency: the byte is visible on data_out/data_present on the clk after the STOP-sample tick clk.
- FIFO:
  - count is FIFO_AW+1 bits; rd_ptr and wr_ptr are FIFO_AW bits and wrap naturally.
  - data_out is mem[rd_ptr] combinationally (FWFT), gated to 0 when empty.
  - A write is accepted if count<FIFO_DEPTH, or if a valid read occurs in the same clk.
  - Simultaneous valid read and accepted write: both pointers advance, count unchanged.
  - A write while full with no read: byte dropped, overrun pulses for 1 clk, pointers and count unchanged.
- Reset (any time, including mid-frame): FSM to IDLE; tick_cnt, bit_cnt and shift_reg to 0; synchronizer to 1; FIFO emptied (pointers and count 0). All outputs 0 afterwards: data_out 8'h00, flags 0, pulses 0. Memory contents are not cleared.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - DATA -> PARITY after the 8th bit. The parity bit is sampled at tick_cnt==15, then -> STOP.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, parity_error pulses for 1 clk at the parity sample. The byte is discarded even if the stop bit is good; the stop bit is still checked and may also raise frame_error.
- Undefined: no PARITY state, DATA -> STOP directly, parity_error tied to 0. The port is always present.

Test Plan:
- Reset, then send 0x55 in 8N1 with real baud-gen ticks -> data_present=1 one clk after the stop sample, data_out=0x55; assert read_buffer for 1 clk -> data_present=0, data_out=0x00.
- While idle, pulse serial_in low for 4 ticks -> no byte, frame_error stays 0, FSM back in IDLE; then send 0x81 -> received as 0x81.
- Send 0xA5 with stop bit 0, hold the line low for 40 ticks, release, then send 0x3C -> exactly one frame_error pulse, FIFO holds only 0x3C.
- FIFO_DEPTH=16, send 0x00..0x10 with no reads -> half_full after the 8th byte, full after the 16th, one overrun pulse on the 17th; reads return 0x00..0x0F in order, then data_present=0.
- With the FIFO full, assert read_buffer on the same clk as the STOP write of 0x77 -> no overrun, count stays 16; 0x77 is read last.
- With UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 0 -> parity_error pulse, FIFO empty.
  - 0x07 with parity bit 1 -> 0x07 received, no errors.
  - Reset asserted mid-DATA -> all outputs 0; the next frame is received cleanly.
